// File: rtl/cl_mul_pkg.sv
// Shared constants, state encoding and line decoder for the cache-line shift-add multiplier.
package cl_mul_pkg;

    localparam int unsigned LineWidth = 512;
    localparam int unsigned ProdWidth = 64;
    localparam int unsigned OperWidth = 32;
    localparam int unsigned CntWidth  = 6;

    localparam logic [31:0] OpMul8    = 32'd1;
    localparam logic [31:0] OpMul8x32 = 32'd2;
    localparam logic [31:0] OpMul32   = 32'd3;

    localparam int unsigned OpcLsb   = 0;
    localparam int unsigned OpcMsb   = 31;
    localparam int unsigned A8Lsb    = 32;
    localparam int unsigned A8Msb    = 39;
    localparam int unsigned B8Lsb    = 40;
    localparam int unsigned B8Msb    = 47;
    localparam int unsigned B8x32Lsb = 40;
    localparam int unsigned B8x32Msb = 71;
    localparam int unsigned A32Lsb   = 32;
    localparam int unsigned A32Msb   = 63;
    localparam int unsigned B32Lsb   = 64;
    localparam int unsigned B32Msb   = 95;

    localparam logic [CntWidth-1:0] Iters8  = 6'd8;
    localparam logic [CntWidth-1:0] Iters32 = 6'd32;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StOut  = 2'd2
    } state_e;

    typedef struct packed {
        logic [OperWidth-1:0] mplier;
        logic [OperWidth-1:0] mcand;
        logic [CntWidth-1:0]  iters;
        logic                 err;
    } op_t;

    function automatic op_t decode_line(input logic [LineWidth-1:0] line);
        op_t op;
        op = '0;
        case (line[OpcMsb:OpcLsb])
            OpMul8: begin
                op.mplier = {24'd0, line[A8Msb:A8Lsb]};
                op.mcand  = {24'd0, line[B8Msb:B8Lsb]};
                op.iters  = Iters8;
            end
            OpMul8x32: begin
                op.mplier = {24'd0, line[A8Msb:A8Lsb]};
                op.mcand  = line[B8x32Msb:B8x32Lsb];
                op.iters  = Iters8;
            end
            OpMul32: begin
                op.mplier = line[A32Msb:A32Lsb];
                op.mcand  = line[B32Msb:B32Lsb];
                op.iters  = Iters32;
            end
            default: op.err = 1'b1;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/cl_mul_shiftadd.sv
// Radix-2 shift-add datapath: one multiplier bit retired per step, fixed iteration count.
module cl_mul_shiftadd
    import cl_mul_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start_i,
    input  logic                 step_i,
    input  logic [OperWidth-1:0] mplier_i,
    input  logic [OperWidth-1:0] mcand_i,
    input  logic [CntWidth-1:0]  iters_i,
    output logic [ProdWidth-1:0] acc_o,
    output logic                 last_o
);

    logic [ProdWidth-1:0] acc_q, acc_d;
    logic [ProdWidth-1:0] mcand_q, mcand_d;
    logic [OperWidth-1:0] mplier_q, mplier_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (start_i) begin
            acc_d    = '0;
            mcand_d  = {{(ProdWidth-OperWidth){1'b0}}, mcand_i};
            mplier_d = mplier_i;
            cnt_d    = iters_i;
        end else if (step_i) begin
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign acc_o  = acc_q;
    // Final step is the one taken while the counter still reads 1.
    assign last_o = (cnt_q == 6'd1);

endmodule

// File: rtl/cl_mul_unit.sv
// Cache-line multiply unit: accepts one opcode line, runs the shift-add datapath, returns a line.
module cl_mul_unit
    import cl_mul_pkg::*;
#(
    parameter int unsigned CACHE_WIDTH = 512
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CACHE_WIDTH-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CACHE_WIDTH-1:0] out_data,
    output logic                   out_err,
    output logic [31:0]            op_cnt
);

    state_e               state_q, state_d;
    logic                 err_q, err_d;
    logic [31:0]          op_cnt_q, op_cnt_d;
    logic                 start, step, last;
    logic [ProdWidth-1:0] acc;
    op_t                  op;

    assign op = decode_line(in_data);

    cl_mul_shiftadd u_shiftadd (
        .clk      (clk),
        .reset_n  (reset_n),
        .start_i  (start),
        .step_i   (step),
        .mplier_i (op.mplier),
        .mcand_i  (op.mcand),
        .iters_i  (op.iters),
        .acc_o    (acc),
        .last_o   (last)
    );

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        op_cnt_d  = op_cnt_q;
        start     = 1'b0;
        step      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    start   = 1'b1;
                    err_d   = op.err;
                    // Unsupported opcodes skip CALC; the datapath load clears acc to zero.
                    state_d = op.err ? StOut : StCalc;
                end
            end
            StCalc: begin
                step = 1'b1;
                if (last) state_d = StOut;
            end
            StOut: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    op_cnt_d = op_cnt_q + 32'd1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            err_q    <= 1'b0;
            op_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            err_q    <= err_d;
            op_cnt_q <= op_cnt_d;
        end
    end

    assign out_data = {{(CACHE_WIDTH-ProdWidth){1'b0}}, acc};
    assign out_err  = err_q & out_valid;
    assign op_cnt   = op_cnt_q;

endmodule

// File: tb/tb_cl_mul_unit.sv
// Self-checking bench for cl_mul_unit against a plain-arithmetic reference model.
module tb_cl_mul_unit;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [511:0] out_data;
    logic         out_err;
    logic [31:0]  op_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_cnt = 0;

    cl_mul_unit #(.CACHE_WIDTH(512)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .op_cnt    (op_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [511:0] rand_line(input logic [31:0] opc);
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
        l[31:0] = opc;
        return l;
    endfunction

    // Reference: operand fields per opcode, product by ordinary multiplication.
    function automatic void model(input logic [511:0] l, output logic [511:0] d,
                                  output logic e, output int n);
        logic [63:0] a, b;
        a = 64'd0; b = 64'd0; e = 1'b0; n = 0;
        case (l[31:0])
            32'd1: begin a = {56'd0, l[39:32]}; b = {56'd0, l[47:40]}; n = 8;  end
            32'd2: begin a = {56'd0, l[39:32]}; b = {32'd0, l[71:40]}; n = 8;  end
            32'd3: begin a = {32'd0, l[63:32]}; b = {32'd0, l[95:64]}; n = 32; end
            default: e = 1'b1;
        endcase
        d = {448'd0, a * b};
    endfunction

    // Presents a line for one edge, then counts edges until out_valid (or -1 on timeout).
    task automatic do_op(input logic [511:0] line, output int lat,
                         output logic [511:0] d, output logic e);
        in_valid = 1'b1;
        in_data  = line;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = rand_line(32'd3);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
        d = out_data;
        e = out_err;
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_cnt++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b out_err=%b want 1 0 0",
                     in_ready, out_valid, out_err);
        end
        n_cmp++;
        if (out_data !== 512'd0 || op_cnt !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_data: out_data=%0h op_cnt=%0d want 0 0", out_data, op_cnt);
        end
        reset_n = 1'b1;
        exp_cnt = 0;
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || op_cnt !== 32'd0) begin
            n_bad++;
            $display("FAIL post_reset: in_ready=%b out_valid=%b op_cnt=%0d want 1 0 0",
                     in_ready, out_valid, op_cnt);
        end
    endtask

    task automatic test_opcode(input string name, input logic [511:0] line,
                               input logic [63:0] want_p, input logic want_e, input int want_n);
        int lat;
        logic [511:0] d;
        logic e;
        do_op(line, lat, d, e);
        n_cmp++;
        if (lat != want_n) begin
            n_bad++;
            $display("FAIL %s_latency: got %0d edges want %0d", name, lat, want_n);
        end
        n_cmp++;
        if (d !== {448'd0, want_p} || e !== want_e) begin
            n_bad++;
            $display("FAIL %s_result: data=%0h err=%b want %0h %b", name, d, e, want_p, want_e);
        end
        finish_op();
        n_cmp++;
        if (op_cnt !== exp_cnt || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_handshake: op_cnt=%0d out_valid=%b in_ready=%b want %0d 0 1",
                     name, op_cnt, out_valid, in_ready, exp_cnt);
        end
    endtask

    task automatic test_stall();
        int lat;
        logic [511:0] d, want_d;
        logic e, want_e;
        int n;
        logic [511:0] l;
        l = rand_line(32'd2);
        model(l, want_d, want_e, n);
        do_op(l, lat, d, e);
        n_cmp++;
        if (d !== want_d || lat != n) begin
            n_bad++;
            $display("FAIL stall_result: data=%0h lat=%0d want %0h %0d", d, lat, want_d, n);
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = rand_line(32'd1);
            @(posedge clk); #1;
            n_cmp++;
            if (out_data !== d || out_err !== e || out_valid !== 1'b1 || in_ready !== 1'b0
                || op_cnt !== exp_cnt) begin
                n_bad++;
                $display("FAIL stall_hold%0d: data=%0h err=%b ov=%b ir=%b cnt=%0d want %0h %b 1 0 %0d",
                         i, out_data, out_err, out_valid, in_ready, op_cnt, d, e, exp_cnt);
            end
        end
        in_valid = 1'b0;
        finish_op();
        n_cmp++;
        if (op_cnt !== exp_cnt) begin
            n_bad++;
            $display("FAIL stall_count: op_cnt=%0d want %0d", op_cnt, exp_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int lat, n;
        logic [511:0] d, want_d, l;
        logic e, want_e;
        test_opcode("b2b_first", {416'd0, 32'd9, 32'd11, 32'd1}, 64'd0, 1'b0, 8);
        l = rand_line(32'd1);
        l[39:32] = 8'd9;
        l[47:40] = 8'd11;
        do_op(rand_line(32'd1), lat, d, e);
        // New line is offered during the OUT handshake cycle and must not be taken then.
        in_valid  = 1'b1;
        in_data   = l;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_cnt++;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || op_cnt !== exp_cnt) begin
            n_bad++;
            $display("FAIL b2b_no_accept: in_ready=%b out_valid=%b op_cnt=%0d want 1 0 %0d",
                     in_ready, out_valid, op_cnt, exp_cnt);
        end
        model(l, want_d, want_e, n);
        do_op(l, lat, d, e);
        n_cmp++;
        if (lat != n || d !== want_d || e !== want_e) begin
            n_bad++;
            $display("FAIL b2b_second: lat=%0d data=%0h err=%b want %0d %0h %b",
                     lat, d, e, n, want_d, want_e);
        end
        finish_op();
    endtask

    task automatic test_random();
        int lat, n, stall;
        logic [511:0] d, want_d, l;
        logic e, want_e;
        logic [31:0] opc;
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 4))
                0: opc = 32'd1;
                1: opc = 32'd2;
                2: opc = 32'd3;
                3: opc = $urandom;
                default: opc = 32'd0;
            endcase
            l = rand_line(opc);
            model(l, want_d, want_e, n);
            do_op(l, lat, d, e);
            n_cmp++;
            if (lat != n || d !== want_d || e !== want_e) begin
                n_bad++;
                $display("FAIL random%0d op=%0h: lat=%0d data=%0h err=%b want %0d %0h %b",
                         i, opc, lat, d, e, n, want_d, want_e);
            end
            stall = $urandom_range(0, 2);
            repeat (stall) begin @(posedge clk); #1; end
            finish_op();
            n_cmp++;
            if (op_cnt !== exp_cnt) begin
                n_bad++;
                $display("FAIL random%0d_count: op_cnt=%0d want %0d", i, op_cnt, exp_cnt);
            end
        end
    endtask

    task automatic test_reset_midcalc();
        logic [511:0] l;
        int seen;
        l = rand_line(32'd3);
        in_valid = 1'b1;
        in_data  = l;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        exp_cnt = 0;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || op_cnt !== 32'd0) begin
            n_bad++;
            $display("FAIL midcalc_reset: in_ready=%b out_valid=%b op_cnt=%0d want 1 0 0",
                     in_ready, out_valid, op_cnt);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        n_cmp++;
        if (seen != 0 || op_cnt !== 32'd0) begin
            n_bad++;
            $display("FAIL midcalc_discard: out_valid cycles=%0d op_cnt=%0d want 0 0",
                     seen, op_cnt);
        end
    endtask

    initial begin
        logic [511:0] l;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        test_reset();
        l = rand_line(32'd1);
        l[39:32] = 8'hFF;
        l[47:40] = 8'hFF;
        test_opcode("op1_max", l, 64'hFE01, 1'b0, 8);
        l = rand_line(32'd2);
        l[39:32] = 8'h03;
        l[71:40] = 32'h4000_0000;
        test_opcode("op2", l, 64'hC000_0000, 1'b0, 8);
        l = rand_line(32'd3);
        l[63:32] = 32'hFFFF_FFFF;
        l[95:64] = 32'hFFFF_FFFF;
        test_opcode("op3_max", l, 64'hFFFF_FFFE_0000_0001, 1'b0, 32);
        test_opcode("op3_zero", {448'd0, 32'd0, 32'd3}, 64'd0, 1'b0, 32);
        test_opcode("bad_op7", rand_line(32'd7), 64'd0, 1'b1, 0);
        test_opcode("bad_op0", rand_line(32'd0), 64'd0, 1'b1, 0);
        test_stall();
        test_back_to_back();
        test_random();
        test_reset_midcalc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cl_mul_unit.md
CL_MUL_UNIT -- requirements
Module: cl_mul_unit

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock.
REQ-002 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-003 SHALL have port in_valid, input, 1, read-response cache line is presented.
REQ-004 SHALL have port in_ready, output, 1, unit accepts a line this cycle.
REQ-005 SHALL have port in_data, input, 512, cache line: [31:0] opcode, operands above.
REQ-006 SHALL have port out_valid, output, 1, result line is presented.
REQ-007 SHALL have port out_ready, input, 1, write-request side accepts the result.
REQ-008 SHALL have port out_data, output, 512, result line: product in [63:0], zero elsewhere.
REQ-009 SHALL have port out_err, output, 1, qualifies out_data; high means unsupported opcode.
REQ-010 SHALL have port op_cnt, output, 32, number of completed output handshakes.
REQ-011 SHALL have parameter CACHE_WIDTH, default 512, line width; only 512 is supported.

Function
REQ-012 SHALL use states IDLE, CALC, OUT; in_ready=1 only in IDLE; out_valid=1 only in OUT.
REQ-013 SHALL treat an input handshake as in_valid&in_ready at a rising edge, and capture the operands at that edge.
REQ-014 SHALL decode opcode 1: A=[39:32] (multiplier), B=[47:40], N=8.
REQ-015 SHALL decode opcode 2: A=[39:32] (multiplier), B=[71:40], N=8.
REQ-016 SHALL decode opcode 3: A=[63:32] (multiplier), B=[95:64], N=32.
REQ-017 SHALL treat any other opcode as an error: go directly to OUT with out_data=0 and out_err=1 (N=0).
REQ-018 SHALL compute the product by radix-2 shift-add, one multiplier bit per CALC cycle: if mplier[0] then acc+=mcand; mcand<<=1; mplier>>=1.
REQ-019 SHALL use a 64-bit accumulator and a 64-bit multiplicand, with operands zero-extended (unsigned); product SHALL never truncate.
REQ-020 SHALL spend exactly N cycles in CALC regardless of operand values, with no early exit on zero.
REQ-021 SHALL, for a handshake at edge k, first assert out_valid after edge k+N.
REQ-022 SHALL hold out_data and out_err stable while out_valid=1 and out_ready=0.
REQ-023 SHALL, on out_valid&out_ready, return to IDLE and increment op_cnt (wrapping 0xFFFFFFFF->0).
REQ-024 SHALL include error results in op_cnt.
REQ-025 SHALL process one operation at a time: a new line is not accepted in the OUT-handshake cycle, and in_ready rises the cycle after.
REQ-026 SHALL ignore in_data while not in IDLE.

Reset
REQ-027 SHALL, while reset_n=0 at a clock edge, enter IDLE and clear acc, mcand, mplier, counter and op_cnt.
REQ-028 SHALL hold these output values during and immediately after reset: in_ready=1, out_valid=0, out_data=0, out_err=0, op_cnt=0.
REQ-029 SHALL, on reset during CALC or OUT, discard the operation without producing output.

Structure
REQ-030 SHALL take the opcode constants (1/2/3), operand bit-field positions, iteration counts and state encoding from the shared package cl_mul_pkg.
REQ-031 SHALL place the shift-add datapath (acc/mcand/mplier/counter) in the sub-module cl_mul_shiftadd; the FSM and handshakes SHALL stay in cl_mul_unit.

Verification
REQ-032 SHALL test: opcode 1, [39:32]=0xFF, [47:40]=0xFF -> out_data[63:0]=0xFE01, out_err=0, out_valid after 8 edges.
REQ-033 SHALL test: opcode 2, A=0x03, B=0x40000000 -> out_data[63:0]=0xC0000000, out_valid after 8 edges.
REQ-034 SHALL test: opcode 3, A=B=0xFFFFFFFF -> out_data[63:0]=0xFFFFFFFE00000001, out_valid after 32 edges, upper bits 0.
REQ-035 SHALL test: opcode 7 -> out_valid after edge k, out_err=1, out_data=0, op_cnt increments.
REQ-036 SHALL test: out_ready held low 5 cycles -> out_data stable, in_ready=0, op_cnt unchanged until the handshake.
REQ-037 SHALL test: reset_n low at CALC cycle 10 of opcode 3 -> IDLE, in_ready=1, no out_valid, op_cnt=0.
